lcd_pio_edge_in: RTL and testbench
==================================

// Module: lcd_pio_edge_in
// PURPOSE
//  Avalon-MM slave input PIO: the reading counterpart of the LCD output PIOs.
//  Samples LCD-side status/touch pins (touch-IRQ, busy, ...) into the clk domain.
//  Detects edges and latches them in a capture register.
//  Raises a maskable level interrupt to the Nios processor.
//  Sits on the same system bus as the LCD PWM/control PIOs.
// PARAMETERS
//  WIDTH       4   number of input pins (1..32)
//  EDGE_TYPE   0   0 = rising, 1 = falling, 2 = any edge
//  SYNC_STAGES 2   synchroniser flops per pin (>=2)
// PORTS
//  clk         in   1      system clock; all logic rising-edge
//  reset       in   1      async, active-high; clears all state
//  address     in   2      register select
//  chipselect  in   1      slave select
//  read_n      in   1      active-low read strobe (informational; reads have no side effects)
//  write_n     in   1      active-low write strobe
//  writedata   in   32     write data
//  in_port     in   WIDTH  asynchronous LCD-side pins
//  readdata    out  32     read data, combinational, zero wait states
//  irq         out  1      registered level interrupt
// BEHAVIOUR
//  Register map:
//   0 DATA  RO  synchronised pin value
//   1 RSVD  RO  reads 0; writes ignored
//   2 MASK  RW  irq_mask[WIDTH-1:0]
//   3 EDGE  W1C edge_capture[WIDTH-1:0]
//  Reset: sync chain, edge-delay reg, irq_mask, edge_capture and irq all 0.
//   readdata at reset = 0 whenever address selects 0..3 (all sources cleared).
//  Synchronisation: pin sampled into SYNC_STAGES-deep chain.
//   sync = last stage; prev = sync delayed one clk.
//  Latency (SYNC_STAGES=2, pin stable before edge k):
//   sync updates at edge k+1.
//   DATA readback shows it after k+1.
//   edge_capture bit sets at edge k+2.
//   irq asserts at edge k+3.
//  Edge detect, per bit:
//   rise = sync & ~prev; fall = ~sync & prev.
//   Selected event sets edge_capture[i]; the bit stays set until cleared.
//  Write: chipselect & ~write_n.
//   addr 2 loads irq_mask <= writedata[WIDTH-1:0].
//   addr 3 clears edge_capture bits where writedata[i]=1; 0 bits unaffected.
//   Writes to addr 0 or 1 are ignored.
//  Simultaneous W1C clear and new edge on the same bit in the same cycle: set wins (bit = 1).
//  irq <= |(edge_capture & irq_mask), evaluated every clk.
//   Mask write or capture clear drops irq on the following edge.
//  Read: readdata = zero-extended selected register, bits [31:WIDTH] = 0.
//   Pure combinational mux on address; no side effects.
//  Pulses shorter than one clk may be missed; no guarantee below 1 clk period.
//  Reset asserted mid-operation: all state cleared immediately (async); pending edges lost.
//   First clk after release re-seeds the chain; prev=0, so a pin high at release
//   produces one rising event after SYNC_STAGES+1 edges (documented, intended).
// TESTING
//  1 Reset: assert reset with in_port=4'hF -> readdata=0 at addr 0..3, irq=0; hold reset,
//    no change on clk.
//  2 Latency: WIDTH=4, EDGE_TYPE=0, mask=4'h1; drive in_port 0->1 on bit0 before edge k
//    -> DATA=1 after k+1, EDGE=1 after k+2, irq=1 after k+3.
//  3 Edge types: EDGE_TYPE=1, falling pulse on bit2 -> EDGE=4'h4.
//    EDGE_TYPE=2, toggle bit1 twice, clear between -> captured both times.
//  4 W1C: EDGE=4'hB; write 32'h2 to addr 3 -> EDGE=4'h9.
//    Write 0 -> unchanged. Write 32'hF -> 0, irq drops next edge.
//  5 Collision: W1C of bit3 in same cycle its edge is detected -> bit3 remains 1, irq stays high.
//  6 Mask/readback: write 32'hFFFF_FFFF to addr 2 -> readback 32'h0000_000F.
//    With EDGE=4'h8 and mask=0 -> irq=0; set mask bit3 -> irq=1 next edge.
//    Writes to addr 0/1 leave state unchanged.

Source files
------------

// File: rtl/lcd_pio_edge_in.sv
// Avalon-MM input PIO for LCD status/touch pins: synchronises pins, latches selected edges
// into a W1C capture register and raises a maskable registered level interrupt.
module lcd_pio_edge_in #(
  parameter int WIDTH       = 4,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain;
  logic [WIDTH-1:0] pin_sync;
  logic [WIDTH-1:0] pin_prev;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] clr_bits;
  logic             wr_en;
  logic             mask_wr;

  // Reads are side-effect free, so the read strobe and the upper write bits carry no state.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, read_n, writedata};

  // Stage 0 takes the raw pin; the last stage is the only one the rest of the logic sees.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_chain <= '0;
      pin_prev   <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], in_port};
      pin_prev   <= pin_sync;
    end
  end

  assign pin_sync = sync_chain[SYNC_STAGES-1];

  always_comb begin
    edge_evt = '0;
    case (EDGE_TYPE)
      0:       edge_evt = pin_sync & ~pin_prev;
      1:       edge_evt = ~pin_sync & pin_prev;
      default: edge_evt = pin_sync ^ pin_prev;
    endcase
  end

  assign wr_en    = chipselect & ~write_n;
  assign mask_wr  = wr_en && (address == ADDR_MASK);
  assign clr_bits = (wr_en && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

  // A new edge overrides a same-cycle clear so no event is ever lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_capture <= '0;
      irq_mask     <= '0;
      irq          <= 1'b0;
    end else begin
      edge_capture <= (edge_capture & ~clr_bits) | edge_evt;
      if (mask_wr) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      irq <= |(edge_capture & irq_mask);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = pin_sync;
      ADDR_MASK: readdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: readdata[WIDTH-1:0] = edge_capture;
      default:   readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_lcd_pio_edge_in.sv
// Bench for lcd_pio_edge_in: rising, falling and any-edge instances share one bus and pin set,
// checked every cycle against a pin-history reference model plus directed constant checks.
module tb_lcd_pio_edge_in;

  localparam int W = 4;
  localparam int S = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    address = 2'd0;
  logic          chipselect = 1'b0;
  logic          read_n = 1'b1;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = 32'd0;
  logic [W-1:0]  in_port = '0;
  logic [31:0]   rd_r, rd_f, rd_a;
  logic          irq_r, irq_f, irq_a;

  int total = 0;
  int bad = 0;

  // Reference model: pin values seen at each edge since reset release, newest last.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_cap[3];
  logic [W-1:0] m_mask[3];
  logic         m_irq[3];

  always #5 clk = ~clk;

  lcd_pio_edge_in #(.WIDTH(W), .EDGE_TYPE(0), .SYNC_STAGES(S)) u_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_r), .irq(irq_r));

  lcd_pio_edge_in #(.WIDTH(W), .EDGE_TYPE(1), .SYNC_STAGES(S)) u_fall (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_f), .irq(irq_f));

  lcd_pio_edge_in #(.WIDTH(W), .EDGE_TYPE(2), .SYNC_STAGES(S)) u_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_a), .irq(irq_a));

  function automatic logic [W-1:0] pin_at(int back);
    int idx;
    idx = hist.size() - 1 - back;
    if (idx < 0) return '0;
    return hist[idx];
  endfunction

  function automatic logic [31:0] dut_rd(int i);
    case (i)
      0:       return rd_r;
      1:       return rd_f;
      default: return rd_a;
    endcase
  endfunction

  function automatic logic dut_irq(int i);
    case (i)
      0:       return irq_r;
      1:       return irq_f;
      default: return irq_a;
    endcase
  endfunction

  function automatic logic [31:0] model_rd(int i);
    logic [31:0] v;
    v = '0;
    case (address)
      2'd0:    v[W-1:0] = pin_at(S - 1);
      2'd2:    v[W-1:0] = m_mask[i];
      2'd3:    v[W-1:0] = m_cap[i];
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s/rd%0d", tag, i), dut_rd(i), model_rd(i));
      check($sformatf("%s/irq%0d", tag, i), {31'd0, dut_irq(i)}, {31'd0, m_irq[i]});
    end
  endtask

  task automatic model_clear();
    hist.delete();
    for (int i = 0; i < 3; i++) begin
      m_cap[i] = '0;
      m_mask[i] = '0;
      m_irq[i] = 1'b0;
    end
  endtask

  // One clock edge: the model advances from the inputs present at the edge, then all outputs are compared.
  task automatic tick(string tag);
    logic [W-1:0] sy, pv, ev, clr;
    logic [W-1:0] n_cap[3];
    logic [W-1:0] n_mask[3];
    logic         n_irq[3];
    logic         wr;
    if (!reset) hist.push_back(in_port);
    sy  = pin_at(S);
    pv  = pin_at(S + 1);
    wr  = chipselect && !write_n;
    clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
    for (int i = 0; i < 3; i++) begin
      ev = (i == 0) ? (sy & ~pv) : (i == 1) ? (~sy & pv) : (sy ^ pv);
      n_cap[i]  = (m_cap[i] & ~clr) | ev;
      n_mask[i] = (wr && address == 2'd2) ? writedata[W-1:0] : m_mask[i];
      n_irq[i]  = |(m_cap[i] & m_mask[i]);
    end
    @(posedge clk);
    #1;
    if (reset) begin
      model_clear();
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_cap[i] = n_cap[i];
        m_mask[i] = n_mask[i];
        m_irq[i] = n_irq[i];
      end
    end
    check_all(tag);
  endtask

  task automatic ticks(string tag, int n);
    for (int k = 0; k < n; k++) tick(tag);
  endtask

  task automatic bus_write(string tag, logic [1:0] a, logic [31:0] d);
    address = a;
    chipselect = 1'b1;
    write_n = 1'b0;
    writedata = d;
    tick(tag);
    chipselect = 1'b0;
    write_n = 1'b1;
    writedata = 32'd0;
  endtask

  task automatic select(string tag, logic [1:0] a);
    address = a;
    #1;
    check_all(tag);
  endtask

  task automatic assert_reset(string tag);
    reset = 1'b1;
    #1;
    model_clear();
    check_all(tag);
  endtask

  initial begin
    model_clear();

    // Reset with all pins high: every register reads zero and nothing moves while held.
    in_port = 4'hF;
    tick("pre");
    assert_reset("rst_async");
    ticks("rst_hold", 3);
    for (int a = 0; a < 4; a++) begin
      select("rst_addr", a[1:0]);
      check("rst_rd_r", rd_r, 32'd0);
    end
    check("rst_irq", {31'd0, irq_r}, 32'd0);
    reset = 1'b0;
    address = 2'd3;
    ticks("rst_release", 4);
    check("rst_reseed_rise", rd_r, 32'hF);
    check("rst_reseed_fall", rd_f, 32'h0);

    // Latency from a rising pin on bit0 with mask bit0.
    in_port = 4'h0;
    ticks("lat_settle", 4);
    bus_write("lat_clr", 2'd3, 32'hF);
    bus_write("lat_mask", 2'd2, 32'h1);
    address = 2'd0;
    in_port = 4'h1;
    tick("lat_k");
    check("lat_data_k", rd_r, 32'h0);
    tick("lat_k1");
    check("lat_data_k1", rd_r, 32'h1);
    address = 2'd3;
    tick("lat_k2");
    check("lat_edge_k2", rd_r, 32'h1);
    check("lat_irq_k2", {31'd0, irq_r}, 32'd0);
    tick("lat_k3");
    check("lat_irq_k3", {31'd0, irq_r}, 32'd1);

    // Falling pulse on bit2 and double toggle of bit1 for the any-edge instance.
    in_port = 4'h5;
    ticks("fall_setup", 4);
    bus_write("fall_clr", 2'd3, 32'hF);
    in_port = 4'h1;
    tick("fall_low");
    in_port = 4'h5;
    ticks("fall_high", 4);
    check("fall_cap", rd_f, 32'h4);
    bus_write("any_clr", 2'd3, 32'hF);
    in_port = in_port ^ 4'h2;
    ticks("any_t1", 4);
    check("any_cap1", rd_a & 32'h2, 32'h2);
    bus_write("any_clr1", 2'd3, 32'h2);
    check("any_cleared", rd_a & 32'h2, 32'h0);
    in_port = in_port ^ 4'h2;
    ticks("any_t2", 4);
    check("any_cap2", rd_a & 32'h2, 32'h2);

    // Write-one-to-clear behaviour starting from a capture of 4'hB.
    in_port = 4'h0;
    ticks("w1c_settle", 4);
    bus_write("w1c_clr", 2'd3, 32'hF);
    in_port = 4'hB;
    ticks("w1c_fill", 4);
    check("w1c_B", rd_r, 32'hB);
    bus_write("w1c_2", 2'd3, 32'h2);
    check("w1c_9", rd_r, 32'h9);
    bus_write("w1c_0", 2'd3, 32'h0);
    check("w1c_keep", rd_r, 32'h9);
    bus_write("w1c_F", 2'd3, 32'hF);
    check("w1c_all", rd_r, 32'h0);
    tick("w1c_irq_drop");
    check("w1c_irq", {31'd0, irq_r}, 32'd0);

    // Clear of bit3 in the very cycle its rising edge is captured.
    bus_write("col_mask", 2'd2, 32'h8);
    in_port = 4'h3;
    ticks("col_low", 4);
    in_port = 4'hB;
    ticks("col_rise", 4);
    check("col_irq_pre", {31'd0, irq_r}, 32'd1);
    in_port = 4'h3;
    ticks("col_low2", 3);
    in_port = 4'hB;
    ticks("col_k", 2);
    bus_write("col_w1c", 2'd3, 32'h8);
    check("col_cap", rd_r & 32'h8, 32'h8);
    tick("col_after");
    check("col_irq", {31'd0, irq_r}, 32'd1);

    // Mask readback width, mask gating of irq and ignored writes.
    bus_write("mask_all", 2'd2, 32'hFFFF_FFFF);
    check("mask_rb", rd_r, 32'h0000_000F);
    bus_write("mask_zero", 2'd2, 32'h0);
    tick("mask_zero_irq");
    check("mask_irq0", {31'd0, irq_r}, 32'd0);
    bus_write("mask_b3", 2'd2, 32'h8);
    tick("mask_b3_irq");
    check("mask_irq1", {31'd0, irq_r}, 32'd1);
    bus_write("ign0", 2'd0, 32'hFFFF_FFFF);
    bus_write("ign1", 2'd1, 32'hFFFF_FFFF);
    select("ign_rsvd", 2'd1);
    check("rsvd_zero", rd_r, 32'h0);
    select("ign_mask", 2'd2);
    check("ign_mask_rb", rd_r, 32'h8);

    // Reset in the middle of activity loses everything pending.
    in_port = 4'h0;
    tick("mid_pre");
    assert_reset("mid_rst");
    tick("mid_hold");
    reset = 1'b0;
    ticks("mid_release", 2);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) in_port = W'($urandom_range(0, 15));
      address = 2'($urandom_range(0, 3));
      chipselect = 1'($urandom_range(0, 1));
      write_n = ($urandom_range(0, 3) != 0);
      read_n = 1'($urandom_range(0, 1));
      writedata = $urandom;
      if ($urandom_range(0, 149) == 0) begin
        assert_reset("rnd_rst");
        tick("rnd_rst_hold");
        reset = 1'b0;
      end
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
